// File: rtl/iram_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle instruction RAM.
// m0 is a read-only fetch port, m1 a read/write data port; every transaction takes IDLE->ACCESS->RESP.
module iram_arbiter #(
    parameter logic [63:0] RAM_START = 64'h0002_0000,
    parameter logic [63:0] RAM_SIZE  = 64'd1072
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        m0_req,
    input  logic [63:0] m0_addr,
    output logic        m0_ready,
    output logic        m0_err,
    output logic [63:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [63:0] m1_rdata,
    output logic        HWRITE,
    output logic [63:0] HADDR,
    output logic [63:0] HWDATA,
    input  logic [63:0] HRDATA
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Window bounds widened by one bit so RAM_START+RAM_SIZE cannot wrap.
    localparam logic [64:0] WIN_LO = {1'b0, RAM_START};
    localparam logic [64:0] WIN_HI = {1'b0, RAM_START} + {1'b0, RAM_SIZE} - 65'd8;

    logic [1:0]  state_q, state_d;
    logic        last_m1_q, last_m1_d;
    logic        sel_m1_q, sel_m1_d;
    logic        write_q, write_d;
    logic        legal_q, legal_d;
    logic        hwrite_q, hwrite_d;
    logic [63:0] haddr_q, haddr_d;
    logic [63:0] hwdata_q, hwdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m0_err_q, m0_err_d;
    logic [63:0] m0_rdata_q, m0_rdata_d;
    logic        m1_ready_q, m1_ready_d;
    logic        m1_err_q, m1_err_d;
    logic [63:0] m1_rdata_q, m1_rdata_d;

    logic        grant_m1;
    logic [63:0] win_addr;
    logic [63:0] win_wdata;
    logic        win_write;
    logic        win_legal;

    // Winner selection and legality of the address about to be latched.
    always_comb begin
        grant_m1  = m1_req && (!m0_req || !last_m1_q);
        win_addr  = grant_m1 ? m1_addr : m0_addr;
        win_wdata = grant_m1 ? m1_wdata : 64'd0;
        win_write = grant_m1 && m1_write;
        win_legal = (win_addr[2:0] == 3'd0)
                 && ({1'b0, win_addr} >= WIN_LO)
                 && ({1'b0, win_addr} <= WIN_HI);
    end

    // Next-state and registered-output logic; bus outputs default to zero.
    always_comb begin
        state_d    = state_q;
        last_m1_d  = last_m1_q;
        sel_m1_d   = sel_m1_q;
        write_d    = write_q;
        legal_d    = legal_q;
        hwrite_d   = 1'b0;
        haddr_d    = 64'd0;
        hwdata_d   = 64'd0;
        m0_ready_d = 1'b0;
        m0_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_ready_d = 1'b0;
        m1_err_d   = 1'b0;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d   = ST_ACCESS;
                    last_m1_d = grant_m1;
                    sel_m1_d  = grant_m1;
                    write_d   = win_write;
                    legal_d   = win_legal;
                    hwrite_d  = win_legal && win_write;
                    haddr_d   = win_legal ? win_addr : 64'd0;
                    hwdata_d  = win_legal ? win_wdata : 64'd0;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (legal_q && !write_q) begin
                    if (sel_m1_q) m1_rdata_d = HRDATA;
                    else          m0_rdata_d = HRDATA;
                end
                m0_ready_d = !sel_m1_q;
                m0_err_d   = !sel_m1_q && !legal_q;
                m1_ready_d = sel_m1_q;
                m1_err_d   = sel_m1_q && !legal_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state_q    <= ST_IDLE;
            last_m1_q  <= 1'b1;
            sel_m1_q   <= 1'b0;
            write_q    <= 1'b0;
            legal_q    <= 1'b0;
            hwrite_q   <= 1'b0;
            haddr_q    <= 64'd0;
            hwdata_q   <= 64'd0;
            m0_ready_q <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= 64'd0;
            m1_ready_q <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            last_m1_q  <= last_m1_d;
            sel_m1_q   <= sel_m1_d;
            write_q    <= write_d;
            legal_q    <= legal_d;
            hwrite_q   <= hwrite_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
            m0_ready_q <= m0_ready_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ready_q <= m1_ready_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign HWRITE   = hwrite_q;
    assign HADDR    = haddr_q;
    assign HWDATA   = hwdata_q;
    assign m0_ready = m0_ready_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ready = m1_ready_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;

endmodule
